led_ti_sbox_layer: RTL and testbench
====================================

Name: led_ti_sbox_layer

Overview:
- Parametrised threshold-implementation S-box layer for the LED datapath.
- Applies the 4-bit LED/PRESENT S-box to a full shared state of NIBBLES nibbles, using LANES parallel 3-share G/F instances.
- Time-multiplexes the nibble slices through a two-stage (G then F) register pipeline.
- Sits between AddConstants and ShiftRows in the masked round. Takes 2 input shares plus fresh masks and produces 2 or 3 output shares.

Parameters:
- NIBBLES, 16, nibbles per state; the LED state is 64 bits.
- LANES, 4, S-box instances in parallel. NIBBLES % LANES == 0, else elaboration error.
- OUT_SHARES, 3, output share count; only 2 or 3 is legal, else elaboration error.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- start  in  1  request; sampled only in IDLE
- share_a  in  4*NIBBLES  input share A; nibble j at [4j+3:4j]
- share_b  in  4*NIBBLES  input share B; unshared x = share_a ^ share_b
- mask  in  8*NIBBLES  fresh randomness; m1_j = [8j+3:8j], m2_j = [8j+7:8j+4]
- q_share0  out  4*NIBBLES  output share 0
- q_share1  out  4*NIBBLES  output share 1
- q_share2  out  4*NIBBLES  output share 2
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (reset==0 at a rising edge): FSM=IDLE; all capture, pipeline and output registers = 0; busy=0, done=0. Reset mid-operation aborts with no partial result kept.
- FSM states and transitions:
  - IDLE: start=1 → capture share_a, share_b, mask into internal registers; slice counter=0; go to RUN.
  - RUN: each cycle, slice k = nibbles k*LANES..k*LANES+LANES-1 passes through the G stage into the y registers; counter++. After slice P-1 (P = NIBBLES/LANES) go to DRAIN.
  - DRAIN: F stage writes the last slice → DONE.
  - DONE: done=1 for one cycle → IDLE.
- Pipelining: the F stage processes slice k-1 while G processes slice k. Output slice k is written one cycle after its G cycle.
- Latency: done is high in the cycle P+2 edges after the edge that sampled start. For LANES=NIBBLES this is 3 cycles (G, F, DONE).
- Busy rules: start while busy=1 is ignored; the captured inputs are not disturbed. Inputs may change freely after the capture edge.
- Per-nibble sharing:
  - Remask: n1 = m1^m2, n2 = a^m2, n3 = b^m1.
  - G stage: y1 = G1(n2,n3), y2 = G2(n1,n3), y3 = G3(n1,n2), using the team's standard 3-share G component functions.
  - F stage: s1 = F1(y1,y2), s2 = F2(y1,y3), s3 = F3(y2,y3), using the team's standard 3-share F component functions.
  - Non-completeness: no function sees all three shares.
  - Correctness: s1^s2^s3 = S(a^b), with S = C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
- Output mapping:
  - OUT_SHARES=3: q_share0=s1, q_share1=s2, q_share2=s3.
  - OUT_SHARES=2: q_share0 = s1^s2 (XOR computed after the F registers), q_share1 = s3, q_share2 = 0 constant.
- Output hold: outputs change only on F-stage slice writes. Earlier slices of a new operation overwrite progressively. Values are guaranteed coherent only from the done cycle until the next accepted start's first F write.
- Simultaneous events: start asserted in the DONE cycle is ignored; start is sampled only in IDLE.

Test Plan:
- NIBBLES=16, LANES=4, OUT_SHARES=3, share_a=0x0123456789ABCDEF, share_b=0, mask=0, start pulse → done 6 cycles after the start edge, exactly one cycle wide; q0^q1^q2 = 0xC56B90AD3EF84712; busy high for cycles 1..5.
- Same x re-split with random share_b and random mask, repeated for 1000 random trials → XOR of output shares always equals S(x) per nibble. Additionally, with share_a/share_b/mask uniform over all 2^16 values for a single nibble, each individual output share depends on at most two of (n1,n2,n3) (checked structurally).
- start held high continuously for 20 cycles → ops complete back-to-back every 7 cycles; no extra done pulses; captured inputs are not changed by mid-op input toggling.
- reset=0 asserted during the RUN cycle 2 → next cycle: all outputs 0, busy=0, done=0; a subsequent start gives a correct result.
- LANES=16 → done exactly 3 cycles after the start edge; x=0xFFFF...F → unshared output 0x2222...2.
- OUT_SHARES=2, x=0x0123456789ABCDEF random split → q_share2==0 always; q_share0^q_share1 = 0xC56B90AD3EF84712.

Source files
------------

// File: rtl/led_ti_sbox_layer_if.sv
// led_ti_sbox_layer_if: request/response and share buses of the TI S-box layer
interface led_ti_sbox_layer_if #(parameter int NIBBLES = 16);
  logic start, busy, done;
  logic [4*NIBBLES-1:0] share_a, share_b, q_share0, q_share1, q_share2;
  logic [8*NIBBLES-1:0] mask;
  modport master(output start, share_a, share_b, mask, input q_share0, q_share1, q_share2, busy, done);
  modport slave(input start, share_a, share_b, mask, output q_share0, q_share1, q_share2, busy, done);
endinterface

// File: rtl/led_ti_sbox_layer.sv
// led_ti_sbox_layer: 3-share threshold S-box layer, LANES nibbles per cycle through G then F stages
module led_ti_sbox_layer #(
  parameter int NIBBLES = 16,
  parameter int LANES = 4,
  parameter int OUT_SHARES = 3
) (
  input logic clk,
  input logic reset,
  led_ti_sbox_layer_if.slave bus
);
  localparam int P = NIBBLES / LANES;
  localparam int W = 4 * LANES;
  localparam int CW = (P > 1) ? $clog2(P) : 1;
  localparam int N = 4 * NIBBLES;
  if (NIBBLES % LANES != 0) begin : g_bad_lanes
    $error("led_ti_sbox_layer: NIBBLES must be a multiple of LANES");
  end
  if (OUT_SHARES != 2 && OUT_SHARES != 3) begin : g_bad_shares
    $error("led_ti_sbox_layer: OUT_SHARES must be 2 or 3");
  end
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, yidx_q, yidx_d;
  logic [N-1:0] cap_a_q, cap_a_d, cap_b_q, cap_b_d;
  logic [2*N-1:0] cap_m_q, cap_m_d;
  logic [W-1:0] y1_q, y1_d, y2_q, y2_d, y3_q, y3_d, gy1, gy2, gy3, fs1, fs2, fs3;
  logic [N-1:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic busy_q, busy_d, done_q, done_d;
  // Cross terms of one monomial restricted to the two shares p and q
  function automatic logic qm(input logic [3:0] p, q, input int i, j);
    return (p[i] & p[j]) ^ (p[i] & q[j]) ^ (q[i] & p[j]);
  endfunction
  // One share of G = quadratic half of the S-box; c carries the constant into exactly one share
  function automatic logic [3:0] g_sh(input logic [3:0] p, q, input logic c);
    return {p[2] ^ p[1] ^ p[0], c ^ p[2] ^ p[1], c ^ p[3] ^ p[1] ^ qm(p, q, 2, 0) ^ qm(p, q, 1, 0),
            c ^ p[0] ^ qm(p, q, 3, 2) ^ qm(p, q, 3, 1) ^ qm(p, q, 2, 1)};
  endfunction
  // One share of F, the second quadratic half, S = F o G
  function automatic logic [3:0] f_sh(input logic [3:0] p, q);
    return {p[2] ^ p[1] ^ p[0] ^ qm(p, q, 3, 0), p[3] ^ qm(p, q, 1, 0),
            p[2] ^ p[1] ^ qm(p, q, 3, 0), p[1] ^ qm(p, q, 2, 0)};
  endfunction
  // Remask two shares into three, then each G share sees only two of them
  function automatic logic [11:0] g_stage(input logic [3:0] a, b, input logic [7:0] m);
    logic [3:0] n1, n2, n3;
    n1 = m[3:0] ^ m[7:4];
    n2 = a ^ m[7:4];
    n3 = b ^ m[3:0];
    return {g_sh(n2, n3, 1'b1), g_sh(n3, n1, 1'b0), g_sh(n1, n2, 1'b0)};
  endfunction
  // G stage on the current slice and F stage on the slice held in the y registers
  always_comb begin
    gy1 = '0;
    gy2 = '0;
    gy3 = '0;
    fs1 = '0;
    fs2 = '0;
    fs3 = '0;
    for (int l = 0; l < LANES; l++) begin
      {gy1[4*l+:4], gy2[4*l+:4], gy3[4*l+:4]} = g_stage(cap_a_q[4*(int'(cnt_q)*LANES+l)+:4],
        cap_b_q[4*(int'(cnt_q)*LANES+l)+:4], cap_m_q[8*(int'(cnt_q)*LANES+l)+:8]);
      fs1[4*l+:4] = f_sh(y1_q[4*l+:4], y2_q[4*l+:4]);
      fs2[4*l+:4] = f_sh(y3_q[4*l+:4], y1_q[4*l+:4]);
      fs3[4*l+:4] = f_sh(y2_q[4*l+:4], y3_q[4*l+:4]);
    end
  end
  // Sequencing: capture in IDLE, one G slice per RUN cycle, F trails G by one cycle
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    yidx_d = yidx_q;
    cap_a_d = cap_a_q;
    cap_b_d = cap_b_q;
    cap_m_d = cap_m_q;
    y1_d = y1_q;
    y2_d = y2_q;
    y3_d = y3_q;
    s1_d = s1_q;
    s2_d = s2_q;
    s3_d = s3_q;
    done_d = 1'b0;
    if ((state_q == RUN && cnt_q != '0) || state_q == DRAIN) begin
      s1_d[int'(yidx_q)*W+:W] = fs1;
      s2_d[int'(yidx_q)*W+:W] = fs2;
      s3_d[int'(yidx_q)*W+:W] = fs3;
    end
    if (state_q == IDLE && bus.start) begin
      cap_a_d = bus.share_a;
      cap_b_d = bus.share_b;
      cap_m_d = bus.mask;
      cnt_d = '0;
      state_d = RUN;
    end
    if (state_q == RUN) begin
      y1_d = gy1;
      y2_d = gy2;
      y3_d = gy3;
      yidx_d = cnt_q;
      cnt_d = cnt_q + 1'b1;
      state_d = (cnt_q == CW'(P - 1)) ? DRAIN : RUN;
    end
    if (state_q == DRAIN) state_d = DONE;
    if (state_q == DONE) begin
      state_d = IDLE;
      done_d = 1'b1;
    end
    busy_d = state_d != IDLE;
  end
  // State registers, cleared by the active-low synchronous reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      yidx_q <= '0;
      cap_a_q <= '0;
      cap_b_q <= '0;
      cap_m_q <= '0;
      y1_q <= '0;
      y2_q <= '0;
      y3_q <= '0;
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      yidx_q <= yidx_d;
      cap_a_q <= cap_a_d;
      cap_b_q <= cap_b_d;
      cap_m_q <= cap_m_d;
      y1_q <= y1_d;
      y2_q <= y2_d;
      y3_q <= y3_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign bus.q_share0 = (OUT_SHARES == 2) ? s1_q ^ s2_q : s1_q;
  assign bus.q_share1 = (OUT_SHARES == 2) ? s3_q : s2_q;
  assign bus.q_share2 = (OUT_SHARES == 2) ? '0 : s3_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_led_ti_sbox_layer.sv
// tb_led_ti_sbox_layer: random-share checks of the TI S-box layer against a table model
module tb_led_ti_sbox_layer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [3:0] sbox [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                            4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  always #5 clk = ~clk;
  led_ti_sbox_layer_if #(.NIBBLES(16)) i0 ();
  led_ti_sbox_layer_if #(.NIBBLES(16)) i1 ();
  led_ti_sbox_layer_if #(.NIBBLES(16)) i2 ();
  led_ti_sbox_layer #(.NIBBLES(16), .LANES(4), .OUT_SHARES(3)) d0 (.clk(clk), .reset(reset), .bus(i0));
  led_ti_sbox_layer #(.NIBBLES(16), .LANES(16), .OUT_SHARES(3)) d1 (.clk(clk), .reset(reset), .bus(i1));
  led_ti_sbox_layer #(.NIBBLES(16), .LANES(4), .OUT_SHARES(2)) d2 (.clk(clk), .reset(reset), .bus(i2));
  function automatic logic [63:0] sbox64(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[4*i+:4] = sbox[x[4*i+:4]];
    return r;
  endfunction
  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction
  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [63:0] a, b, input logic [127:0] m, input logic s);
    i0.share_a = a; i0.share_b = b; i0.mask = m; i0.start = s;
    i1.share_a = a; i1.share_b = b; i1.mask = m; i1.start = s;
    i2.share_a = a; i2.share_b = b; i2.mask = m; i2.start = s;
  endtask
  task automatic run_op(input logic [63:0] a, b, input logic [127:0] m, input string tag);
    logic [63:0] exp;
    int lat0, lat1, lat2, nd0, nd1, nd2;
    exp = sbox64(a ^ b);
    lat0 = -1; lat1 = -1; lat2 = -1; nd0 = 0; nd1 = 0; nd2 = 0;
    @(negedge clk);
    drive(a, b, m, 1'b1);
    @(posedge clk);
    #1 drive(r64(), r64(), r128(), 1'b0);
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      #1;
      if (i0.done) begin nd0++; lat0 = k; end
      if (i1.done) begin nd1++; lat1 = k; end
      if (i2.done) begin nd2++; lat2 = k; end
      chk({tag, "_busy_l4"}, 64'(i0.busy), 64'(k <= 5));
      chk({tag, "_busy_l16"}, 64'(i1.busy), 64'(k <= 2));
    end
    chk({tag, "_lat_l4"}, 64'(lat0), 64'd6);
    chk({tag, "_lat_l16"}, 64'(lat1), 64'd3);
    chk({tag, "_lat_s2"}, 64'(lat2), 64'd6);
    chk({tag, "_ndone"}, 64'(nd0 + nd1 + nd2), 64'd3);
    chk({tag, "_y_l4"}, i0.q_share0 ^ i0.q_share1 ^ i0.q_share2, exp);
    chk({tag, "_y_l16"}, i1.q_share0 ^ i1.q_share1 ^ i1.q_share2, exp);
    chk({tag, "_y_s2"}, i2.q_share0 ^ i2.q_share1, exp);
    chk({tag, "_q2_zero"}, i2.q_share2, 64'd0);
  endtask
  initial begin
    logic [63:0] x, b, hx [31];
    drive(64'd0, 64'd0, 128'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q0", i0.q_share0, 64'd0);
    chk("rst_q1", i0.q_share1, 64'd0);
    chk("rst_q2", i0.q_share2, 64'd0);
    chk("rst_busy", 64'(i0.busy), 64'd0);
    chk("rst_done", 64'(i0.done), 64'd0);
    reset = 1'b1;
    run_op(64'h0123456789ABCDEF, 64'd0, 128'd0, "directed");
    chk("directed_val", i0.q_share0 ^ i0.q_share1 ^ i0.q_share2, 64'hC56B90AD3EF84712);
    run_op(64'hFFFFFFFFFFFFFFFF, 64'd0, r128(), "all_f");
    chk("all_f_val", i1.q_share0 ^ i1.q_share1 ^ i1.q_share2, 64'h2222222222222222);
    b = r64();
    run_op(64'h0123456789ABCDEF ^ b, b, r128(), "split2");
    chk("split2_val", i2.q_share0 ^ i2.q_share1, 64'hC56B90AD3EF84712);
    for (int t = 0; t < 1000; t++) begin
      x = r64();
      b = r64();
      run_op(x ^ b, b, r128(), "rand");
    end
    @(negedge clk);
    b = r64();
    hx[0] = 64'h0123456789ABCDEF;
    drive(hx[0] ^ b, b, r128(), 1'b1);
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      chk("b2b_done", 64'(i0.done), 64'(k == 6 || k == 13 || k == 20));
      if (i0.done && k >= 6) chk("b2b_y", i0.q_share0 ^ i0.q_share1 ^ i0.q_share2, sbox64(hx[k-6]));
      b = r64();
      hx[k+1] = r64();
      drive(hx[k+1] ^ b, b, r128(), 1'(k + 1 <= 19));
    end
    @(negedge clk);
    drive(r64(), r64(), r128(), 1'b1);
    @(posedge clk);
    #1 drive(r64(), r64(), r128(), 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_q0", i0.q_share0, 64'd0);
    chk("abort_q1", i0.q_share1, 64'd0);
    chk("abort_q2", i0.q_share2, 64'd0);
    chk("abort_s2_q0", i2.q_share0, 64'd0);
    chk("abort_busy", 64'(i0.busy), 64'd0);
    chk("abort_done", 64'(i0.done), 64'd0);
    reset = 1'b1;
    b = r64();
    run_op(r64(), b, r128(), "after_abort");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
